// File: rtl/ssd_capture.sv
// Loopback monitor for a two-digit, active-low, time-multiplexed seven-segment bus.
// Waits for each digit to be held stable under its strobe, decodes it, and emits the byte.
module ssd_capture #(
   parameter int STABLE = 4
) (
   input  logic       i_clk,
   input  logic       i_clr,
   input  logic [6:0] i_seg,
   input  logic [1:0] i_dig,
   output logic [7:0] o_q,
   output logic       o_valid,
   output logic       o_err,
   output logic [3:0] o_frames
);

   typedef enum logic [1:0] {WAIT_LO, WAIT_HI, EMIT} state_t;

   localparam logic [3:0] STABLE_C = 4'(STABLE);

   state_t     r_state, w_state_nx;
   logic [6:0] r_seg_d;
   logic [1:0] r_dig_d;
   logic [3:0] r_run, w_run_inc, w_run_nx;
   logic [3:0] r_lo_nib, r_hi_nib;
   logic       r_lo_bad, r_hi_bad;
   logic [1:0] w_target;
   logic       w_capture;
   logic [3:0] w_nib;
   logic       w_bad;

   // Returns {illegal, nibble}; unknown codes (including blank) decode to 0.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'h40: return 5'h00;
         7'h79: return 5'h01;
         7'h24: return 5'h02;
         7'h30: return 5'h03;
         7'h19: return 5'h04;
         7'h12: return 5'h05;
         7'h02: return 5'h06;
         7'h78: return 5'h07;
         7'h00: return 5'h08;
         7'h18: return 5'h09;
         7'h08: return 5'h0A;
         7'h03: return 5'h0B;
         7'h46: return 5'h0C;
         7'h21: return 5'h0D;
         7'h06: return 5'h0E;
         7'h0E: return 5'h0F;
         default: return 5'h10;
      endcase
   endfunction

   always_comb begin
      w_target   = (r_state == WAIT_HI) ? 2'b10 : 2'b01;
      {w_bad, w_nib} = decode(i_seg);
      w_run_inc  = 4'd0;
      if (i_dig == w_target && r_dig_d == w_target && i_seg == r_seg_d)
         w_run_inc = (r_run >= STABLE_C) ? STABLE_C : r_run + 4'd1;
      else if (i_dig == w_target)
         w_run_inc = 4'd1;
      w_capture  = (r_state != EMIT) && (w_run_inc == STABLE_C);
      w_state_nx = r_state;
      w_run_nx   = w_run_inc;
      case (r_state)
         WAIT_LO: begin
            if (w_capture) begin
               w_state_nx = WAIT_HI;
               w_run_nx   = 4'd0;
            end
         end
         WAIT_HI: begin
            if (w_capture) begin
               w_state_nx = EMIT;
               w_run_nx   = 4'd0;
            end else if (i_dig == 2'b11) begin
               w_state_nx = WAIT_LO;
               w_run_nx   = 4'd0;
            end
         end
         default: begin
            w_state_nx = WAIT_LO;
            w_run_nx   = 4'd0;
         end
      endcase
   end

   // Outputs load on the high-digit capture edge so Valid is high during EMIT.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state  <= WAIT_LO;
         r_run    <= 4'd0;
         r_seg_d  <= 7'h7F;
         r_dig_d  <= 2'b00;
         r_lo_nib <= 4'd0;
         r_hi_nib <= 4'd0;
         r_lo_bad <= 1'b0;
         r_hi_bad <= 1'b0;
         o_q      <= 8'h00;
         o_valid  <= 1'b0;
         o_err    <= 1'b0;
         o_frames <= 4'd0;
      end else begin
         r_state <= w_state_nx;
         r_run   <= w_run_nx;
         r_seg_d <= i_seg;
         r_dig_d <= i_dig;
         o_valid <= 1'b0;
         if (r_state == WAIT_LO && w_capture) begin
            r_lo_nib <= w_nib;
            r_lo_bad <= w_bad;
         end
         if (r_state == WAIT_HI) begin
            if (w_capture) begin
               r_hi_nib <= w_nib;
               r_hi_bad <= w_bad;
               o_q      <= {w_nib, r_lo_nib};
               o_err    <= w_bad | r_lo_bad;
               o_valid  <= 1'b1;
               o_frames <= o_frames + 4'd1;
            end else if (i_dig == 2'b11) begin
               r_lo_nib <= 4'd0;
               r_lo_bad <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture: reset, framing, glitch restart, illegal codes,
// collision abort, clear mid-frame and frame-count wrap.
module tb_ssd_capture;

   logic       clk = 1'b0;
   logic       clr;
   logic [6:0] seg;
   logic [1:0] dig;
   logic [7:0] q;
   logic       valid;
   logic       err;
   logic [3:0] frames;

   int checks = 0;
   int fails  = 0;

   logic [6:0] pat [16];

   ssd_capture #(.STABLE(4)) dut (
      .i_clk(clk), .i_clr(clr), .i_seg(seg), .i_dig(dig),
      .o_q(q), .o_valid(valid), .o_err(err), .o_frames(frames)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are read there too.
   task automatic step(input logic [6:0] s, input logic [1:0] d);
      seg = s;
      dig = d;
      @(negedge clk);
   endtask

   task automatic hold(input logic [6:0] s, input logic [1:0] d, input int n);
      for (int i = 0; i < n; i++) step(s, d);
   endtask

   task automatic test_reset;
      clr = 1'b1;
      hold(7'h12, 2'b11, 2);
      checks++; if (q !== 8'h00)     begin fails++; $display("FAIL reset_q got %h want 00", q); end
      checks++; if (valid !== 1'b0)  begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (err !== 1'b0)    begin fails++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (frames !== 4'd0) begin fails++; $display("FAIL reset_frames got %0d want 0", frames); end
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(7'h19, 2'b00);
         checks++; if (valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %b want 0", valid); end
      end
   endtask

   task automatic test_basic;
      hold(7'h19, 2'b01, 4);
      hold(7'h02, 2'b10, 3);
      checks++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", valid); end
      step(7'h02, 2'b10);
      checks++; if (valid !== 1'b1)  begin fails++; $display("FAIL basic_valid got %b want 1", valid); end
      checks++; if (q !== 8'h64)     begin fails++; $display("FAIL basic_q got %h want 64", q); end
      checks++; if (err !== 1'b0)    begin fails++; $display("FAIL basic_err got %b want 0", err); end
      checks++; if (frames !== 4'd1) begin fails++; $display("FAIL basic_frames got %0d want 1", frames); end
      step(7'h7F, 2'b00);
      checks++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b want 0", valid); end
      checks++; if (q !== 8'h64)    begin fails++; $display("FAIL basic_q_hold got %h want 64", q); end
   endtask

   task automatic test_glitch;
      hold(7'h40, 2'b01, 3);
      hold(7'h79, 2'b01, 4);
      hold(7'h0E, 2'b10, 4);
      checks++; if (valid !== 1'b1)  begin fails++; $display("FAIL glitch_valid got %b want 1", valid); end
      checks++; if (q !== 8'hF1)     begin fails++; $display("FAIL glitch_q got %h want F1", q); end
      checks++; if (frames !== 4'd2) begin fails++; $display("FAIL glitch_frames got %0d want 2", frames); end
      step(7'h7F, 2'b00);
   endtask

   task automatic test_illegal;
      hold(7'h7F, 2'b01, 4);
      hold(7'h00, 2'b10, 4);
      checks++; if (valid !== 1'b1)  begin fails++; $display("FAIL illegal_valid got %b want 1", valid); end
      checks++; if (err !== 1'b1)    begin fails++; $display("FAIL illegal_err got %b want 1", err); end
      checks++; if (q !== 8'h80)     begin fails++; $display("FAIL illegal_q got %h want 80", q); end
      checks++; if (frames !== 4'd3) begin fails++; $display("FAIL illegal_frames got %0d want 3", frames); end
      step(7'h7F, 2'b00);
   endtask

   task automatic test_abort;
      hold(7'h24, 2'b01, 4);
      step(7'h24, 2'b11);
      checks++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b want 0", valid); end
      // Back in WAIT_LO: a high-digit strobe alone must not finish a frame.
      for (int i = 0; i < 5; i++) begin
         step(7'h12, 2'b10);
         checks++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_hi_only_valid got %b want 0", valid); end
      end
      step(7'h7F, 2'b00);
      hold(7'h30, 2'b01, 4);
      hold(7'h12, 2'b10, 4);
      checks++; if (valid !== 1'b1)  begin fails++; $display("FAIL abort_new_valid got %b want 1", valid); end
      checks++; if (q !== 8'h53)     begin fails++; $display("FAIL abort_new_q got %h want 53", q); end
      checks++; if (err !== 1'b0)    begin fails++; $display("FAIL abort_new_err got %b want 0", err); end
      checks++; if (frames !== 4'd4) begin fails++; $display("FAIL abort_new_frames got %0d want 4", frames); end
      step(7'h7F, 2'b00);
   endtask

   task automatic test_clear_mid_frame;
      clr = 1'b1;
      step(7'h7F, 2'b00);
      clr = 1'b0;
      hold(7'h24, 2'b01, 4);
      hold(7'h12, 2'b10, 2);
      clr = 1'b1;
      step(7'h12, 2'b10);
      clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(7'h12, 2'b10);
         checks++; if (valid !== 1'b0) begin fails++; $display("FAIL clr_hi_valid got %b want 0", valid); end
      end
      checks++; if (frames !== 4'd0) begin fails++; $display("FAIL clr_hi_frames got %0d want 0", frames); end
      step(7'h7F, 2'b00);
   endtask

   task automatic test_wrap;
      logic [7:0] b;
      logic [3:0] fexp;
      for (int i = 0; i < 17; i++) begin
         b    = 8'(i);
         fexp = 4'(i + 1);
         hold(pat[b[3:0]], 2'b01, 4);
         hold(pat[b[7:4]], 2'b10, 4);
         checks++; if (valid !== 1'b1) begin fails++; $display("FAIL wrap_valid[%0d] got %b want 1", i, valid); end
         checks++; if (q !== b)        begin fails++; $display("FAIL wrap_q[%0d] got %h want %h", i, q, b); end
         checks++; if (frames !== fexp) begin fails++; $display("FAIL wrap_frames[%0d] got %0d want %0d", i, frames, fexp); end
         step(7'h7F, 2'b00);
         checks++; if (valid !== 1'b0) begin fails++; $display("FAIL wrap_pulse[%0d] got %b want 0", i, valid); end
      end
   endtask

   initial begin
      pat[0]  = 7'h40; pat[1]  = 7'h79; pat[2]  = 7'h24; pat[3]  = 7'h30;
      pat[4]  = 7'h19; pat[5]  = 7'h12; pat[6]  = 7'h02; pat[7]  = 7'h78;
      pat[8]  = 7'h00; pat[9]  = 7'h18; pat[10] = 7'h08; pat[11] = 7'h03;
      pat[12] = 7'h46; pat[13] = 7'h21; pat[14] = 7'h06; pat[15] = 7'h0E;
      clr = 1'b1;
      seg = 7'h7F;
      dig = 2'b00;
      @(negedge clk);
      test_reset;
      test_basic;
      test_glitch;
      test_illegal;
      test_abort;
      test_clear_mid_frame;
      test_wrap;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
